fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the rv32im_zbb pipeline; sits between instruction memory and the ID stage.
//  Generalises the single-register PC/IF-ID path into a decoupled fetcher.
//  - Handshaked memory port (req/gnt/rvalid) with up to MAX_OUTSTANDING requests in flight.
//  - Prefetch FIFO of {pc, instr} entries; valid/ready output to decode.
//  - Single-cycle redirect (branch/jump/flush) that discards stale in-flight responses.
// PARAMETERS
//  XLEN            32      address/PC width
//  RESET_PC        0       PC fetched first after reset
//  FIFO_DEPTH      4       prefetch entries; power of 2, >=2
//  MAX_OUTSTANDING 2       max granted-but-unanswered requests, 1..FIFO_DEPTH
// PORTS
//  clk                 in   1              clock, rising edge
//  rst                 in   1              asynchronous reset, active-high
//  redirect_i          in   1              flush and restart fetch at redirect_pc_i
//  redirect_pc_i       in   XLEN           new PC; bits [1:0] ignored (forced 0)
//  instr_mem_req_o     out  1              fetch request
//  instr_mem_address_o out  XLEN           fetch address, word aligned
//  instr_mem_gnt_i     in   1              request accepted this cycle
//  instr_mem_rvalid_i  in   1              response valid; in request order
//  instr_mem_read_i    in   32             response instruction word
//  if_valid_o          out  1              FIFO head valid
//  if_ready_i          in   1              decode accepts head
//  if_instr_o          out  32             head instruction
//  if_pc_o             out  XLEN           head PC
//  fifo_count_o        out  clog2(D+1)     current FIFO occupancy
//  protocol_err_o      out  1              sticky: rvalid seen with nothing in flight
// BEHAVIOUR
//  Reset (async, rst=1)
//   - req_o=0, address_o=RESET_PC, if_valid_o=0, fifo_count_o=0, protocol_err_o=0.
//   - fetch_pc=RESET_PC, resp_pc=RESET_PC, inflight=0, discard=0.
//   - Asserting rst mid-operation abandons all state; later rvalids are the memory's responsibility.
//  Issue
//   - req_o = !redirect_i && inflight<MAX_OUTSTANDING && (fifo_count+inflight-discard)<FIFO_DEPTH.
//   - address_o=fetch_pc. On req&gnt: fetch_pc+=4 (wraps modulo 2^XLEN), inflight++.
//   - address_o is held stable while req=1 && gnt=0; only redirect may withdraw a pending request.
//  Response
//   - On rvalid: inflight--.
//   - If discard>0: discard--, data dropped.
//   - Else push {resp_pc, instr} and resp_pc+=4.
//   - The credit rule guarantees a push never finds the FIFO full (assertion in bench).
//   - rvalid with inflight==0: ignored, protocol_err_o<=1 until reset.
//  Output
//   - if_valid_o = fifo_count!=0; pop on if_valid_o&&if_ready_i.
//   - Push and pop in the same cycle leave the count unchanged.
//   - Latency: grant at cycle t, rvalid at t+k (k>=1), head valid at t+k+1 if FIFO was empty (no bypass).
//  Redirect (single cycle, priority over everything)
//   - FIFO cleared; pop ignored; req_o forced 0 this cycle.
//   - fetch_pc, resp_pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
//   - discard <= inflight - rvalid: responses already in flight are dropped.
//   - inflight updates normally.
//   - Fetch restarts the next cycle. Back-to-back redirects: the last one wins.
//  Counters: inflight and discard are clog2(MAX_OUTSTANDING+1) bits wide; discard<=inflight always.
// STRUCTURE
//  - Shared include rv_defs.vh: XLEN, NOP encoding 32'h00000013, ILEN=32.
//  - Sub-module sync_fifo (WIDTH=XLEN+32, DEPTH): registered, with synchronous clear input,
//    count output and async reset; reusable by later stages.
//  - fetch_unit holds the PC/credit/discard logic only.
// TESTING
//  1. Reset release, gnt=1, rvalid 1 cycle after grant, ready=1:
//     addresses 0,4,8,...; if_pc_o 0,4,8 with first if_valid_o 3 cycles after rst drop.
//  2. if_ready_i=0 with D=4: exactly 4 grants then req_o=0; fifo_count_o=4.
//     Ready=1 for one cycle -> one pop and exactly one new request.
//  3. Two requests in flight (0,4), redirect to 0x100 before responses:
//     both responses dropped; first if_pc_o=0x100, if_instr_o=mem[0x100].
//  4. Redirect in the same cycle as an rvalid and a pop: FIFO empty next cycle,
//     discard=inflight-1, no stale PC ever reaches the output.
//  5. gnt held low 5 cycles: address_o stable, req_o stays 1;
//     fetch_pc=0xFFFFFFFC then wraps to 0 after the grant.
//  6. Spurious rvalid with inflight=0: no push, protocol_err_o=1 and it stays set.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage.
// Imported by fetch_unit and available to later pipeline stages.
package fetch_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned PC_STEP  = 4;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO with synchronous clear and occupancy count.
// Generic enough to be reused by later pipeline stages.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (!w_full || w_pop);

  // storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // pointers and occupancy; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetcher: credit-limited memory requests,
// prefetch FIFO towards decode, redirect with stale-response discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  localparam int unsigned    CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_mem_req_o,
  output logic [XLEN-1:0] instr_mem_address_o,
  input  logic            instr_mem_gnt_i,
  input  logic            instr_mem_rvalid_i,
  input  logic [ILEN-1:0] instr_mem_read_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [ILEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [CW-1:0]   fifo_count_o,
  output logic            protocol_err_o
);

  localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW = XLEN + ILEN;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   r_discard;
  logic            r_perr;

  logic [XLEN-1:0] w_redirect_pc;
  logic [CW:0]     w_occ;
  logic            w_req;
  logic            w_fire;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic [CW-1:0]   w_fifo_count;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

  // slots already promised: queued entries plus live requests
  assign w_occ = (CW+1)'(w_fifo_count)
               + (CW+1)'(r_inflight)
               - (CW+1)'(r_discard);

  assign w_req = !rst && !redirect_i
              && (r_inflight < IW'(MAX_OUTSTANDING))
              && (w_occ < (CW+1)'(FIFO_DEPTH));

  assign w_fire = w_req && instr_mem_gnt_i;
  assign w_rsp  = instr_mem_rvalid_i && (r_inflight != '0);
  assign w_drop = w_rsp && (r_discard != '0);
  assign w_push = w_rsp && !w_drop && !redirect_i;
  assign w_pop  = if_valid_o && if_ready_i && !redirect_i;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect_i),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, instr_mem_read_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  // request and response PCs; redirect overrides both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + XLEN'(PC_STEP);
      end
    end
  end

  // in-flight credit and count of responses still to be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + IW'(w_fire) - IW'(w_rsp);
      if (redirect_i) begin
        r_discard <= r_inflight - IW'(w_rsp);
      end else if (w_drop) begin
        r_discard <= r_discard - IW'(1);
      end
    end
  end

  // sticky flag for a response arriving with nothing requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (instr_mem_rvalid_i && (r_inflight == '0)) begin
      r_perr <= 1'b1;
    end
  end

  assign instr_mem_req_o     = w_req;
  assign instr_mem_address_o = r_fetch_pc;
  assign if_valid_o          = (w_fifo_count != '0);
  assign if_pc_o             = w_head[EW-1:ILEN];
  assign if_instr_o          = if_valid_o ? w_head[ILEN-1:0]
                                          : NOP_INSTR;
  assign fifo_count_o        = w_fifo_count;
  assign protocol_err_o      = r_perr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order memory model.
module tb_fetch_unit;

  localparam int D  = 4;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  count;
  logic        perr;

  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        spur = 1'b0;
  logic [31:0] spur_data = '0;
  logic        rsp_en = 1'b0;
  logic [31:0] pend [$];
  logic        s_fire;
  logic [31:0] s_addr;

  int checks = 0;
  int errors = 0;

  assign rvalid = m_rvalid | spur;
  assign rdata  = m_rvalid ? m_rdata : spur_data;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN            (32),
    .RESET_PC        (32'h0),
    .FIFO_DEPTH      (D),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_i          (redirect),
    .redirect_pc_i       (redirect_pc),
    .instr_mem_req_o     (req),
    .instr_mem_address_o (addr),
    .instr_mem_gnt_i     (gnt),
    .instr_mem_rvalid_i  (rvalid),
    .instr_mem_read_i    (rdata),
    .if_valid_o          (valid),
    .if_ready_i          (ready),
    .if_instr_o          (instr),
    .if_pc_o             (pc),
    .fifo_count_o        (count),
    .protocol_err_o      (perr)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory: grant seen at an edge is answered in the next cycle
  always begin
    @(negedge clk);
    s_fire = req && gnt && !rst;
    s_addr = addr;
    @(posedge clk);
    #2;
    m_rvalid = 1'b0;
    if (rst) begin
      pend.delete();
    end else begin
      if (s_fire) pend.push_back(s_addr);
      if (rsp_en && pend.size() > 0) begin
        m_rvalid = 1'b1;
        m_rdata  = memw(pend.pop_front());
      end
    end
  end

  // occupancy must never exceed depth (a push never hits a full FIFO)
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (count <= 3'(D)) else begin
        errors++;
        $error("FAIL fifo_bound observed=%0d expected<=%0d", count, D);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    spur = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    grants = 0;

    // reset values
    gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
    cyc(); settle();
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_perr", 64'(perr), 64'(0));

    // 1: streaming, 1-cycle memory latency
    do_reset(); settle();
    chk("t1_req", 64'(req), 64'(1));
    chk("t1_addr0", 64'(addr), 64'(0));
    chk("t1_valid_c1", 64'(valid), 64'(0));
    cyc(); settle();
    chk("t1_addr4", 64'(addr), 64'(4));
    chk("t1_valid_c2", 64'(valid), 64'(0));
    cyc(); settle();
    chk("t1_valid_c3", 64'(valid), 64'(1));
    chk("t1_pc0", 64'(pc), 64'(0));
    chk("t1_instr0", 64'(instr), 64'(memw(0)));
    chk("t1_addr8", 64'(addr), 64'(8));
    cyc(); settle();
    chk("t1_pc4", 64'(pc), 64'(4));
    chk("t1_count", 64'(count), 64'(1));
    cyc(); settle();
    chk("t1_pc8", 64'(pc), 64'(8));
    chk("t1_instr8", 64'(instr), 64'(memw(8)));

    // 2: decode stalled fills FIFO, one pop frees one credit
    ready = 1'b0; gnt = 1'b1; rsp_en = 1'b1;
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (req && gnt) grants++;
      cyc();
    end
    settle();
    chk("t2_grants", 64'(grants), 64'(4));
    chk("t2_count4", 64'(count), 64'(4));
    chk("t2_req_off", 64'(req), 64'(0));
    chk("t2_head0", 64'(pc), 64'(0));
    cyc();
    ready = 1'b1;
    settle();
    chk("t2_req_full", 64'(req), 64'(0));
    cyc();
    ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (req && gnt) grants++;
      cyc();
    end
    settle();
    chk("t2_one_grant", 64'(grants), 64'(1));
    chk("t2_count_refill", 64'(count), 64'(4));
    chk("t2_head4", 64'(pc), 64'(4));
    chk("t2_instr4", 64'(instr), 64'(memw(4)));

    // 3: redirect with two requests outstanding
    ready = 1'b1; gnt = 1'b1; rsp_en = 1'b0;
    do_reset(); settle();
    chk("t3_addr0", 64'(addr), 64'(0));
    cyc(); settle();
    chk("t3_addr4", 64'(addr), 64'(4));
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    chk("t3_req_redir", 64'(req), 64'(0));
    cyc();
    redirect = 1'b0; rsp_en = 1'b1;
    settle();
    chk("t3_valid_c4", 64'(valid), 64'(0));
    chk("t3_req_c4", 64'(req), 64'(0));
    cyc(); settle();
    chk("t3_valid_c5", 64'(valid), 64'(0));
    chk("t3_req_c5", 64'(req), 64'(1));
    chk("t3_addr100", 64'(addr), 64'(32'h100));
    cyc(); settle();
    chk("t3_valid_c6", 64'(valid), 64'(0));
    chk("t3_addr104", 64'(addr), 64'(32'h104));
    cyc(); settle();
    chk("t3_valid_c7", 64'(valid), 64'(1));
    chk("t3_pc100", 64'(pc), 64'(32'h100));
    chk("t3_instr100", 64'(instr), 64'(memw(32'h100)));

    // 4: redirect coinciding with rvalid and pop
    ready = 1'b0; gnt = 1'b1; rsp_en = 1'b1;
    do_reset(); settle();
    cyc(); settle();
    cyc();
    rsp_en = 1'b0;
    settle();
    chk("t4_valid_c3", 64'(valid), 64'(1));
    chk("t4_addr8", 64'(addr), 64'(8));
    cyc();
    rsp_en = 1'b1; ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    settle();
    chk("t4_req_redir", 64'(req), 64'(0));
    chk("t4_head0", 64'(pc), 64'(0));
    chk("t4_rvalid", 64'(rvalid), 64'(1));
    cyc();
    redirect = 1'b0;
    settle();
    chk("t4_valid_c5", 64'(valid), 64'(0));
    chk("t4_count_c5", 64'(count), 64'(0));
    chk("t4_addr200", 64'(addr), 64'(32'h200));
    chk("t4_req_c5", 64'(req), 64'(1));
    cyc(); settle();
    chk("t4_valid_c6", 64'(valid), 64'(0));
    cyc(); settle();
    chk("t4_pc200", 64'(pc), 64'(32'h200));
    chk("t4_instr200", 64'(instr), 64'(memw(32'h200)));
    cyc(); settle();
    chk("t4_pc204", 64'(pc), 64'(32'h204));

    // 5: grant stall, then PC wraps past the top of memory
    ready = 1'b1; gnt = 1'b0; rsp_en = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    settle();
    chk("t5_req_redir", 64'(req), 64'(0));
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_hold_req", 64'(req), 64'(1));
      chk("t5_hold_addr", 64'(addr), 64'(32'hFFFF_FFFC));
      cyc();
    end
    gnt = 1'b1;
    settle();
    chk("t5_gnt_addr", 64'(addr), 64'(32'hFFFF_FFFC));
    cyc(); settle();
    chk("t5_wrap_addr", 64'(addr), 64'(0));
    cyc(); settle();
    chk("t5_pc_top", 64'(pc), 64'(32'hFFFF_FFFC));
    chk("t5_instr_top", 64'(instr), 64'(memw(32'hFFFF_FFFC)));
    cyc(); settle();
    chk("t5_pc_wrap", 64'(pc), 64'(0));

    // 6: spurious response sets the sticky error flag
    ready = 1'b1; gnt = 1'b0; rsp_en = 1'b1;
    do_reset(); settle();
    chk("t6_perr_clr", 64'(perr), 64'(0));
    cyc();
    spur = 1'b1; spur_data = 32'hDEAD_BEEF;
    settle();
    cyc();
    spur = 1'b0;
    settle();
    chk("t6_perr_set", 64'(perr), 64'(1));
    chk("t6_no_push", 64'(count), 64'(0));
    chk("t6_no_valid", 64'(valid), 64'(0));
    cyc(); cyc(); cyc();
    settle();
    chk("t6_perr_sticky", 64'(perr), 64'(1));
    cyc();
    rst = 1'b1;
    settle();
    chk("t6_perr_async_rst", 64'(perr), 64'(0));
    cyc();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
